// File: rtl/ofd_arb_pkg.sv
// Shared types, constants and the round-robin scan used by the UART TX arbiter.
// OFD_ARB_HDR_EN adds the HDR state used to prefix each packet with an ID byte.
package ofd_arb_pkg;

    localparam int WAIT_HI_TIMEOUT = 4;
    localparam int MAX_REQ         = 8;

`ifdef OFD_ARB_HDR_EN
    typedef enum logic [2:0] {
        IDLE, ARB, LOAD, START, WAIT_HI, WAIT_LO, HDR
    } arb_state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ARB, LOAD, START, WAIT_HI, WAIT_LO
    } arb_state_t;
`endif

    // First set index after ptr, wrapping modulo n; falls back to ptr when nothing is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (valid[idx[2:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/ofd_rr_picker.sv
// Combinational round-robin select: request vector plus last-served pointer
// gives the next index to grant and whether any request is present.
module ofd_rr_picker
    import ofd_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = IDX_W'(rr_pick(MAX_REQ'(valid_i), int'(ptr_i), N_REQ));
        found_o = |valid_i;
    end

endmodule

// File: rtl/ofd_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among N_REQ
// byte streams. Define OFD_ARB_HDR_EN to prefix each packet with HDR_BASE | id.
module ofd_uart_tx_arbiter
    import ofd_arb_pkg::*;
#(
    parameter  int                N_REQ    = 4,
    parameter  int                DATA_W   = 8,
    parameter  logic [DATA_W-1:0] HDR_BASE = 8'hA0,
    localparam int                IDX_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    grant_active,
    output logic                    uart_start,
    output logic [DATA_W-1:0]       uart_data,
    input  logic                    uart_busy,
    output logic                    err_timeout
);

    localparam int CNT_W = $clog2(WAIT_HI_TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              grant_active_q, grant_active_d;
    logic [DATA_W-1:0] uart_data_q, uart_data_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;

    ofd_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

`ifndef OFD_ARB_HDR_EN
    // HDR_BASE only shapes the ID byte of the header build.
    if (HDR_BASE != '0) begin : g_hdr_base_unused
    end
`endif

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        uart_data_d    = uart_data_q;
        last_d         = last_q;
        err_d          = err_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        req_ready      = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid) state_d = ARB;
            end
            ARB: begin
                // A request that vanished before arbitration is simply dropped.
                if (pick_found) begin
                    grant_id_d     = pick_idx;
                    grant_active_d = 1'b1;
`ifdef OFD_ARB_HDR_EN
                    state_d        = HDR;
`else
                    state_d        = LOAD;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef OFD_ARB_HDR_EN
            HDR: begin
                // last_d=0 sends WAIT_LO on to LOAD for the owner's first byte.
                uart_data_d = HDR_BASE | DATA_W'(grant_id_q);
                last_d      = 1'b0;
                state_d     = START;
            end
`endif
            LOAD: begin
                req_ready[grant_id_q] = req_valid[grant_id_q];
                if (req_valid[grant_id_q]) begin
                    uart_data_d = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
                    last_d      = req_last[grant_id_q];
                    state_d     = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_W'(WAIT_HI_TIMEOUT - 1)) begin
                    // Silent UART: flag it and treat the byte as sent so nothing hangs.
                    err_d   = 1'b1;
                    state_d = WAIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!uart_busy) begin
                    if (last_q) begin
                        rr_ptr_d       = grant_id_q;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            uart_data_q    <= '0;
            last_q         <= 1'b0;
            err_q          <= 1'b0;
            rr_ptr_q       <= IDX_W'(N_REQ - 1);
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            uart_data_q    <= uart_data_d;
            last_q         <= last_d;
            err_q          <= err_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
        end
    end

    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign uart_start   = (state_q == START);
    assign uart_data    = uart_data_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_ofd_uart_tx_arbiter.sv
// Directed bench for ofd_uart_tx_arbiter: queue-fed requesters, a simple UART
// busy model, and one task per scenario with hand-derived expectations.
module tb_ofd_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int FRAME = 3;
`ifdef OFD_ARB_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [1:0]    grant_id;
    logic          grant_active;
    logic          uart_start;
    logic [DW-1:0] uart_data;
    logic          uart_busy;
    logic          err_timeout;

    ofd_uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .HDR_BASE(8'hA0)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .uart_start   (uart_start),
        .uart_data    (uart_data),
        .uart_busy    (uart_busy),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] rq [N][$];
    logic [7:0] sent_q [$];
    int         gid_q [$];
    int         rdy_log [$];
    int         ready_cnt [N];
    int         onehot_bad = 0;
    logic [7:0] exp_d [$];
    int         exp_g [$];

    logic       busy_en = 1'b1;
    logic [7:0] cur_byte;
    int         left;
    int         pend;

    // Requester driver: presents the head of each queue, pops after a handshake.
    initial begin
        logic [N-1:0] hs;
        logic [8:0]   head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_ready & req_valid;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    ready_cnt[i]++;
                    rdy_log.push_back(i);
                end
            end
            if ($countones(req_ready) > 1) onehot_bad++;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    head = rq[i][0];
                    req_valid[i]          = 1'b1;
                    req_data[i*DW +: DW]  = head[7:0];
                    req_last[i]           = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // UART model: busy one cycle after start, for FRAME cycles; data must hold meanwhile.
    initial begin
        uart_busy = 1'b0;
        left      = 0;
        pend      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1) begin
                left      = 0;
                pend      = 0;
                uart_busy = 1'b0;
            end else begin
                if (left > 0) begin
                    checks++;
                    if (uart_data !== cur_byte) begin
                        errors++;
                        $display("FAIL data_hold got %h want %h", uart_data, cur_byte);
                    end
                    left--;
                    if (left == 0) uart_busy = 1'b0;
                end
                if (pend != 0) begin
                    pend = 0;
                    if (busy_en) begin
                        uart_busy = 1'b1;
                        left      = FRAME;
                    end
                end
                if (uart_start === 1'b1) begin
                    cur_byte = uart_data;
                    sent_q.push_back(uart_data);
                    gid_q.push_back(int'(grant_id));
                    pend = 1;
                end
            end
        end
    end

    task automatic clear_logs();
        sent_q.delete();
        gid_q.delete();
        rdy_log.delete();
        exp_d.delete();
        exp_g.delete();
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    task automatic push_req(input int id, input logic [7:0] b, input logic last);
        rq[id].push_back({last, b});
    endtask

    task automatic exp_pkt_start(input int id);
        if (HDR) begin
            exp_d.push_back(8'hA0 | 8'(id));
            exp_g.push_back(id);
        end
    endtask

    task automatic exp_byte(input int id, input logic [7:0] b);
        exp_d.push_back(b);
        exp_g.push_back(id);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (n < budget && !(rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                               rq[3].size() == 0 && grant_active === 1'b0 && uart_busy === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_idle got timeout after %0d cycles want idle", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== '0)       begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
        checks++; if (grant_id !== 2'd0)      begin errors++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
        checks++; if (grant_active !== 1'b0)  begin errors++; $display("FAIL rst_grant_active got %b want 0", grant_active); end
        checks++; if (uart_start !== 1'b0)    begin errors++; $display("FAIL rst_start got %b want 0", uart_start); end
        checks++; if (uart_data !== 8'h00)    begin errors++; $display("FAIL rst_data got %h want 00", uart_data); end
        checks++; if (err_timeout !== 1'b0)   begin errors++; $display("FAIL rst_err got %b want 0", err_timeout); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        clear_logs();
        exp_pkt_start(0);
        exp_byte(0, 8'h4D);
        push_req(0, 8'h4D, 1'b1);
        wait_idle("single", 80);
        checks++;
        if (sent_q.size() != exp_d.size()) begin
            errors++; $display("FAIL single_count got %0d want %0d", sent_q.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [7:0] gd = 8'hxx;
            int gg = -1;
            if (k < sent_q.size()) begin gd = sent_q[k]; gg = gid_q[k]; end
            checks++;
            if (gd !== exp_d[k] || gg != exp_g[k]) begin
                errors++; $display("FAIL single_byte%0d got %h/id%0d want %h/id%0d", k, gd, gg, exp_d[k], exp_g[k]);
            end
        end
        checks++; if (ready_cnt[0] != 1)     begin errors++; $display("FAIL single_ready got %0d want 1", ready_cnt[0]); end
        checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL single_active got %b want 0", grant_active); end
    endtask

    task automatic test_packet();
        int exp_rdy [4] = '{1, 1, 1, 2};
        clear_logs();
        exp_pkt_start(1);
        exp_byte(1, 8'h11); exp_byte(1, 8'h22); exp_byte(1, 8'h33);
        exp_pkt_start(2);
        exp_byte(2, 8'h77);
        push_req(1, 8'h11, 1'b0); push_req(1, 8'h22, 1'b0); push_req(1, 8'h33, 1'b1);
        push_req(2, 8'h77, 1'b1);
        wait_idle("packet", 150);
        checks++;
        if (sent_q.size() != exp_d.size()) begin
            errors++; $display("FAIL packet_count got %0d want %0d", sent_q.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [7:0] gd = 8'hxx;
            int gg = -1;
            if (k < sent_q.size()) begin gd = sent_q[k]; gg = gid_q[k]; end
            checks++;
            if (gd !== exp_d[k] || gg != exp_g[k]) begin
                errors++; $display("FAIL packet_byte%0d got %h/id%0d want %h/id%0d", k, gd, gg, exp_d[k], exp_g[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            int got = (k < rdy_log.size()) ? rdy_log[k] : -1;
            checks++;
            if (got != exp_rdy[k]) begin
                errors++; $display("FAIL packet_ready_order%0d got %0d want %0d", k, got, exp_rdy[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        push_req(3, 8'h03, 1'b1);
        wait_idle("rr_prefix", 80);
        clear_logs();
        for (int i = 0; i < N; i++) begin
            push_req(i, 8'h10 + 8'(i), 1'b1);
            push_req(i, 8'h20 + 8'(i), 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                exp_pkt_start(i);
                exp_byte(i, 8'(16 * (r + 1) + i));
            end
        end
        wait_idle("rr", 300);
        checks++;
        if (sent_q.size() != exp_d.size()) begin
            errors++; $display("FAIL rr_count got %0d want %0d", sent_q.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [7:0] gd = 8'hxx;
            int gg = -1;
            if (k < sent_q.size()) begin gd = sent_q[k]; gg = gid_q[k]; end
            checks++;
            if (gd !== exp_d[k] || gg != exp_g[k]) begin
                errors++; $display("FAIL rr_byte%0d got %h/id%0d want %h/id%0d", k, gd, gg, exp_d[k], exp_g[k]);
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ready_cnt[i] != 2) begin
                errors++; $display("FAIL rr_ready%0d got %0d want 2", i, ready_cnt[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear_logs();
        busy_en = 1'b0;
        exp_pkt_start(0);
        exp_byte(0, 8'h5A);
        push_req(0, 8'h5A, 1'b1);
        while (uart_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (uart_start !== 1'b1) begin
            errors++; $display("FAIL timeout_start got %b want 1", uart_start);
        end
        repeat (4) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", err_timeout); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", err_timeout); end
        wait_idle("timeout", 120);
        checks++;
        if (sent_q.size() != exp_d.size()) begin
            errors++; $display("FAIL timeout_count got %0d want %0d", sent_q.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [7:0] gd = 8'hxx;
            if (k < sent_q.size()) gd = sent_q[k];
            checks++;
            if (gd !== exp_d[k]) begin
                errors++; $display("FAIL timeout_byte%0d got %h want %h", k, gd, exp_d[k]);
            end
        end
        busy_en = 1'b1;
        push_req(1, 8'h44, 1'b1);
        wait_idle("timeout_sticky", 80);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        clear_logs();
        push_req(1, 8'h31, 1'b0);
        push_req(1, 8'h32, 1'b1);
        while (uart_busy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (uart_busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy got %b want 1", uart_busy);
        end
        @(negedge clk);
        checks++; if (grant_active !== 1'b1) begin errors++; $display("FAIL midrst_pre_active got %b want 1", grant_active); end
        reset = 1'b0;
        #1;
        checks++; if (uart_start !== 1'b0)   begin errors++; $display("FAIL midrst_start got %b want 0", uart_start); end
        checks++; if (req_ready !== '0)      begin errors++; $display("FAIL midrst_ready got %b want 0", req_ready); end
        checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b want 0", grant_active); end
        checks++; if (uart_data !== 8'h00)   begin errors++; $display("FAIL midrst_data got %h want 00", uart_data); end
        checks++; if (err_timeout !== 1'b0)  begin errors++; $display("FAIL midrst_err got %b want 0", err_timeout); end
        for (int i = 0; i < N; i++) rq[i].delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_restart();
        clear_logs();
        exp_pkt_start(2);
        exp_byte(2, 8'h55);
        push_req(2, 8'h55, 1'b1);
        wait_idle("restart", 80);
        checks++;
        if (sent_q.size() != exp_d.size()) begin
            errors++; $display("FAIL restart_count got %0d want %0d", sent_q.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [7:0] gd = 8'hxx;
            int gg = -1;
            if (k < sent_q.size()) begin gd = sent_q[k]; gg = gid_q[k]; end
            checks++;
            if (gd !== exp_d[k] || gg != exp_g[k]) begin
                errors++; $display("FAIL restart_byte%0d got %h/id%0d want %h/id%0d", k, gd, gg, exp_d[k], exp_g[k]);
            end
        end
        checks++; if (ready_cnt[2] != 1) begin errors++; $display("FAIL restart_ready got %0d want 1", ready_cnt[2]); end
    endtask

    task automatic test_onehot();
        checks++;
        if (onehot_bad != 0) begin
            errors++; $display("FAIL ready_onehot got %0d multi-hot cycles want 0", onehot_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_round_robin();
        test_timeout();
        test_reset_mid_frame();
        test_restart();
        test_onehot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ofd_uart_tx_arbiter.md
Name: ofd_uart_tx_arbiter

Overview:
- Shares the single UART transmitter of the top_ofd_uart datapath between N_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until it sends a byte tagged last.
- Drives the UART's start strobe and data byte. Tracks the UART busy flag, so exactly one byte is in flight at any time.
- Sits between the protocol/control logic (requesters) and the UART TX core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the UART.
- HDR_BASE, 8'hA0, header base value (used only with OFD_ARB_HDR_EN); header = HDR_BASE | id.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*DATA_W  per-requester byte; slice i = bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  marks the final byte of a packet.
- req_ready  out  N_REQ  one-hot byte accept; at most one bit high.
- grant_id  out  $clog2(N_REQ)  current owner index; valid when grant_active=1.
- grant_active  out  1  a packet is in progress.
- uart_start  out  1  one-cycle start strobe to the UART (trig_start).
- uart_data  out  DATA_W  byte to the UART (data_in); held stable from uart_start until uart_busy falls.
- uart_busy  in  1  UART transmitting; rises no later than 2 cycles after uart_start.
- err_timeout  out  1  sticky; set if uart_busy fails to rise within 4 cycles of uart_start.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; req_ready=0; grant_id=0; grant_active=0; uart_start=0; uart_data=0; err_timeout=0; rr_ptr=N_REQ-1.
- FSM states: IDLE, ARB, LOAD, START, WAIT_HI, WAIT_LO.
- IDLE: if any req_valid, go to ARB next cycle.
- ARB: pick the first valid index scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo N_REQ. Register grant_id; set grant_active=1; go to LOAD.
- LOAD: req_ready[grant_id]=1 for exactly this cycle, and only when req_valid[grant_id]=1.
  - On handshake, capture data into uart_data and last into last_q, then go to START.
  - If the owner deasserts valid mid-packet, stay in LOAD with grant held. No other requester is served.
- START: uart_start=1 for one cycle; go to WAIT_HI.
- WAIT_HI: wait for uart_busy=1, then go to WAIT_LO.
  - After 4 cycles without uart_busy: set err_timeout and treat the byte as sent (go to the WAIT_LO exit path).
- WAIT_LO: on uart_busy=0:
  - If last_q=0, go to LOAD.
  - If last_q=1: rr_ptr←grant_id, grant_active=0, go to IDLE.
- Minimum per-byte overhead: 3 cycles plus UART frame time. Byte-to-byte latency inside a packet is LOAD→START = 1 cycle after acceptance.
- Only the owner sees req_ready. Requests arriving at other indices mid-packet wait; no preemption.
- A requester whose req_valid drops before being granted is simply skipped. Valid may drop without penalty.
- Requests arriving in IDLE and ARB on the same cycle are resolved by ARB's registered sample.
- If reset asserts mid-frame, all outputs return to reset values immediately. The UART's own reset handles the partial frame.
- err_timeout clears only on reset.

Optional Feature:
- Macro OFD_ARB_HDR_EN.
- Defined: ARB goes to HDR. HDR loads uart_data = HDR_BASE | grant_id and runs the START/WAIT_HI/WAIT_LO sequence once without asserting any req_ready, then continues to LOAD. Every packet is therefore prefixed by one ID byte.
- Undefined: no HDR state; ARB goes directly to LOAD; HDR_BASE is unused.

Decomposition:
- Package ofd_arb_pkg holds:
  - the state enum (arb_state_t);
  - the localparam for the WAIT_HI timeout (4);
  - a function rr_pick(valid, ptr) returning the next index.
- One sub-module is natural: ofd_rr_picker, combinational round-robin select (valid vector + pointer → index, found flag). The FSM stays in the top.

Test Plan:
- Single requester, req 0 sends 1-byte packet 8'h4D with last=1 → one uart_start with uart_data=8'h4D; req_ready[0] pulses once; grant_active returns to 0 after busy falls.
- req 1 sends a 3-byte packet 11,22,33 while req 2 is valid throughout → UART sees 11,22,33 then req 2's byte. req_ready[2] stays 0 until req 1's last byte completes.
- All 4 requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0,1; rr_ptr wraps from 3 to 0.
- UART model never raises busy → err_timeout=1 four cycles after uart_start; FSM returns to IDLE or LOAD with no hang.
- Reset asserted during WAIT_LO → uart_start, req_ready and grant_active go to 0 immediately. After release, the first valid request is granted normally.
- With OFD_ARB_HDR_EN, req 2 sends 8'h55 → UART sees 8'hA2 then 8'h55.
